// File: rtl/data_burst_ctrl.sv
// Burst controller: sequences one 9-beat burst through the external data counter,
// hands each beat to a valid/ready consumer, times out a starved datapath and
// reports completion or a latched fault code.
module data_burst_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic       Abort,
  input  logic       Dp_Valid,
  input  logic       Out_Ready,
  input  logic [3:0] Count,
  input  logic       Done_Flag,
  output logic       En_Count,
  output logic       Show_DATA,
  output logic       Out_Valid,
  output logic       Dp_Advance,
  output logic       Busy,
  output logic       Burst_Done,
  output logic       Err_Flag,
  output logic [1:0] Err_Code
);

  localparam logic [7:0] StallLast = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LastBeat  = 4'd8;

  localparam logic [1:0] CodeNone    = 2'b00;
  localparam logic [1:0] CodeTimeout = 2'b01;
  localparam logic [1:0] CodeArm     = 2'b10;
  localparam logic [1:0] CodeNoDone  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StWaitDone,
    StDone,
    StErr
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] stall_q, stall_d;
  logic       miss_q, miss_d;   // Done_Flag already seen low once in WAIT_DONE
  logic [1:0] err_code_q, err_code_d;
  logic [1:0] fault_code;
  logic       in_run;
  logic       xfer;

  // Moore outputs from state, Mealy handshake outputs gated to RUN
  always_comb begin
    in_run     = (state_q == StRun);
    xfer       = in_run & Dp_Valid & Out_Ready;
    Out_Valid  = in_run & Dp_Valid;
    Show_DATA  = in_run & Out_Ready;
    Dp_Advance = xfer;
    En_Count   = (state_q == StArm) || (state_q == StRun) || (state_q == StWaitDone);
    Busy       = En_Count;
    Burst_Done = (state_q == StDone);
    Err_Flag   = (state_q == StErr);
    Err_Code   = err_code_q;
  end

  // Next state, stall counter, done-miss tracking and fault code
  always_comb begin
    state_d    = state_q;
    stall_d    = '0;
    miss_d     = 1'b0;
    fault_code = CodeNone;
    unique case (state_q)
      StIdle: begin
        if (Start) state_d = StArm;
      end
      StArm: begin
        if (Count == 4'd0 && !Done_Flag) begin
          state_d = StRun;
        end else begin
          state_d    = StErr;
          fault_code = CodeArm;
        end
      end
      StRun: begin
        // A transfer beats the timeout even on the threshold cycle
        if (xfer) begin
          if (Count == LastBeat) state_d = StWaitDone;
        end else if (stall_q == StallLast) begin
          state_d    = StErr;
          fault_code = CodeTimeout;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      StWaitDone: begin
        if (Done_Flag) begin
          state_d = StDone;
        end else if (miss_q) begin
          state_d    = StErr;
          fault_code = CodeNoDone;
        end else begin
          miss_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        if (Start) state_d = StArm;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (Abort) state_d = StIdle;

    // Code is captured on ERR entry, held while in ERR, cleared on any exit
    if (state_d == StErr) begin
      err_code_d = (state_q == StErr) ? err_code_q : fault_code;
    end else begin
      err_code_d = CodeNone;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      stall_q    <= '0;
      miss_q     <= 1'b0;
      err_code_q <= CodeNone;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      miss_q     <= miss_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_data_burst_ctrl.sv
// Bench for data_burst_ctrl: cycle table for the nominal burst, hand sequences for
// backpressure, timeout, counter faults, abort and reset; beat scoreboard on Count.
module tb_data_burst_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start, Abort, Dp_Valid, Out_Ready;
  logic [3:0] Count;
  logic       Done_Flag;
  logic       En_Count, Show_DATA, Out_Valid, Dp_Advance, Busy, Burst_Done, Err_Flag;
  logic [1:0] Err_Code;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  // Count_Data model plus fault injection hooks
  logic [3:0] cnt_model;
  bit         force_cnt  = 1'b0;
  bit         done_stuck = 1'b0;

  localparam logic [8:0] OIdle = 9'b000000000;
  localparam logic [8:0] OBusy = 9'b110000000;
  localparam logic [8:0] ORun  = 9'b111110000;
  localparam logic [8:0] ODone = 9'b000001000;

  logic [8:0] ov;
  assign ov = {En_Count, Busy, Out_Valid, Show_DATA, Dp_Advance, Burst_Done, Err_Flag, Err_Code};

  always #5 CLK = ~CLK;

  data_burst_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .Abort     (Abort),
    .Dp_Valid  (Dp_Valid),
    .Out_Ready (Out_Ready),
    .Count     (Count),
    .Done_Flag (Done_Flag),
    .En_Count  (En_Count),
    .Show_DATA (Show_DATA),
    .Out_Valid (Out_Valid),
    .Dp_Advance(Dp_Advance),
    .Busy      (Busy),
    .Burst_Done(Burst_Done),
    .Err_Flag  (Err_Flag),
    .Err_Code  (Err_Code)
  );

  always @(posedge CLK or negedge RST) begin
    if (!RST)                                cnt_model <= 4'd0;
    else if (!En_Count)                      cnt_model <= 4'd0;
    else if (Dp_Valid && Show_DATA && cnt_model != 4'd9) cnt_model <= cnt_model + 4'd1;
  end
  assign Count     = force_cnt ? 4'd5 : cnt_model;
  assign Done_Flag = !done_stuck && (cnt_model == 4'd9);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each transfer must see the next expected beat index on Count
  always @(negedge CLK) begin
    if (RST && Dp_Advance) begin
      if (exp_q.size() == 0) check("sb_extra_beat", 1, 0);
      else check("sb_beat_count", {28'd0, Count}, exp_q.pop_front());
    end
  end

  task automatic push_beats(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  // Advance one cycle, drive inputs just after the edge, return at mid-cycle
  task automatic step(input bit s, input bit a, input bit v, input bit r);
    @(posedge CLK);
    #1;
    Start = s; Abort = a; Dp_Valid = v; Out_Ready = r;
    @(negedge CLK);
  endtask

  // Run a burst with a per-cycle stimulus pattern until Burst_Done, Err_Flag or budget
  task automatic burst(input int kind, input int max_k, output int bd_k, output int err_k,
                       output logic [1:0] code, output logic en, output int viol);
    bit v, r;
    bd_k = -1; err_k = -1; code = 2'b00; en = 1'b0; viol = 0;
    for (int k = 0; k <= max_k; k++) begin
      case (kind)
        0:       begin v = 1'b1;                  r = k[0]; end
        1:       begin v = (k < 5);               r = 1'b1; end
        2:       begin v = !(k >= 5 && k <= 7);   r = 1'b1; end
        default: begin v = 1'b1;                  r = 1'b1; end
      endcase
      step(k == 0, 1'b0, v, r);
      if (Show_DATA && !Out_Ready) viol++;
      if (Burst_Done) begin bd_k = k; break; end
      if (Err_Flag) begin err_k = k; code = Err_Code; en = En_Count; break; end
    end
  endtask

  typedef struct {
    logic       start;
    logic       dv;
    logic       rdy;
    logic [8:0] exp_o;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bd_k, err_k, viol;
    logic [1:0] code;
    logic en;

    // Nominal zero-stall burst, one row per cycle from the Start cycle
    for (int i = 0; i < 14; i++) begin
      tbl[i].start = (i == 0);
      tbl[i].dv    = 1'b1;
      tbl[i].rdy   = 1'b1;
      if (i == 0 || i == 13)  tbl[i].exp_o = OIdle;
      else if (i == 1 || i == 11) tbl[i].exp_o = OBusy;
      else if (i == 12)       tbl[i].exp_o = ODone;
      else                    tbl[i].exp_o = ORun;
      if (i <= 2)             tbl[i].exp_cnt = 4'd0;
      else if (i <= 10)       tbl[i].exp_cnt = 4'(i - 2);
      else if (i <= 12)       tbl[i].exp_cnt = 4'd9;
      else                    tbl[i].exp_cnt = 4'd0;
    end

    RST = 1'b0; Start = 0; Abort = 0; Dp_Valid = 0; Out_Ready = 0;
    #12;
    check("reset_outputs", {23'd0, ov}, {23'd0, OIdle});
    @(negedge CLK);
    RST = 1'b1;

    push_beats(9);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].start, 1'b0, tbl[i].dv, tbl[i].rdy);
      check($sformatf("nominal_out_c%0d", i), {23'd0, ov}, {23'd0, tbl[i].exp_o});
      check($sformatf("nominal_cnt_c%0d", i), {28'd0, Count}, {28'd0, tbl[i].exp_cnt});
    end
    check("nominal_all_beats", exp_q.size(), 0);

    // Backpressure: Out_Ready toggles, beats land on odd cycles 3..19
    push_beats(9);
    burst(0, 40, bd_k, err_k, code, en, viol);
    check("bp_show_while_not_ready", viol, 0);
    check("bp_done_cycle", bd_k, 21);
    check("bp_no_error", err_k, -1);
    check("bp_all_beats", exp_q.size(), 0);

    // Timeout: 3 beats then 4 stall cycles -> ERR in cycle 9
    push_beats(3);
    burst(1, 30, bd_k, err_k, code, en, viol);
    check("to_err_cycle", err_k, 9);
    check("to_err_code", code, 2'b01);
    check("to_en_count_low", en, 1'b0);
    check("to_beats", exp_q.size(), 0);
    Start = 1'b1;  // sampled in ERR
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_restart_arm", {23'd0, ov}, {23'd0, OBusy});
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_abort_idle", {23'd0, ov}, {23'd0, OIdle});

    // Timeout boundary: 3 stalls then a transfer on the threshold cycle
    push_beats(9);
    burst(2, 40, bd_k, err_k, code, en, viol);
    check("tb_done_cycle", bd_k, 15);
    check("tb_no_error", err_k, -1);
    check("tb_all_beats", exp_q.size(), 0);

    // Counter reads 5 at ARM
    force_cnt = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("arm_state", {23'd0, ov}, {23'd0, OBusy});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("arm_fault", {23'd0, ov}, 32'b000000110);
    force_cnt = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("arm_abort_clears", {23'd0, ov}, {23'd0, OIdle});

    // Done_Flag stuck low -> code 11 two cycles after WAIT_DONE entry
    done_stuck = 1'b1;
    push_beats(9);
    burst(3, 40, bd_k, err_k, code, en, viol);
    check("nd_err_cycle", err_k, 13);
    check("nd_err_code", code, 2'b11);
    check("nd_no_done", bd_k, -1);
    done_stuck = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("nd_abort_clears", {23'd0, ov}, {23'd0, OIdle});

    // Abort after beat 5
    push_beats(5);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_idle", {23'd0, ov}, {23'd0, OIdle});
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("abort_quiet", {23'd0, ov}, {23'd0, OIdle});
    end
    check("abort_count_cleared", {28'd0, Count}, 32'd0);
    check("abort_beats", exp_q.size(), 0);

    // Start and Abort together stay in IDLE
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("start_abort_idle", {23'd0, ov}, {23'd0, OIdle});

    // Asynchronous reset in the middle of RUN
    push_beats(2);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge CLK);
    #2;
    check("rst_pre_run", {23'd0, ov}, {23'd0, ORun});
    RST = 1'b0;
    #1;
    check("rst_async_outputs", {23'd0, ov}, {23'd0, OIdle});
    @(negedge CLK);
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_stays_idle", {23'd0, ov}, {23'd0, OIdle});
    check("rst_beats", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_burst_ctrl.md
# data_burst_ctrl

Controller that sequences one 9-beat output burst through the data counter (`Count_Data`) and hands each beat to a downstream consumer over a valid/ready handshake. It drives the counter's `En_Count` and `Show_DATA` inputs and monitors its `Count` and `Done_Flag` outputs. It also stalls on a starved datapath with a timeout, and reports completion or fault to the host FSM. The datapath's new-result strobe `Dp_Valid` is wired to both this block and the counter's `NEW_OUTPUT`.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive stall cycles in RUN before a timeout fault. Legal range 2..255.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `Start` in 1: burst request, sampled in IDLE and ERR.
- `Abort` in 1: cancel; highest priority.
- `Dp_Valid` in 1: datapath result available.
- `Out_Ready` in 1: consumer ready.
- `Count` in 4: counter value.
- `Done_Flag` in 1: counter done flag.
- `En_Count` out 1: counter enable; low clears the counter.
- `Show_DATA` out 1: counter qualify.
- `Out_Valid` out 1: beat valid to consumer.
- `Dp_Advance` out 1: pop datapath; high on each transfer.
- `Busy` out 1: burst in progress.
- `Burst_Done` out 1: one-cycle completion pulse.
- `Err_Flag` out 1: fault latched.
- `Err_Code` out 2: fault code. 00 none, 01 timeout, 10 arm check, 11 done missing.

## Operation
- **States:** IDLE, ARM, RUN, WAIT_DONE, DONE, ERR. All are held in registers; reset forces IDLE.
- **Moore outputs:**
  - `En_Count` = 1 in ARM, RUN and WAIT_DONE.
  - `Busy` = 1 in the same three states.
  - `Burst_Done` = 1 in DONE.
  - `Err_Flag` = 1 in ERR.
  - `Err_Code` is a register: written on ERR entry, cleared on leaving ERR.
- **Mealy outputs (RUN only, else 0):**
  - `Out_Valid` = `Dp_Valid`.
  - `Show_DATA` = `Out_Ready`.
  - transfer = `Dp_Valid & Out_Ready`.
  - `Dp_Advance` = transfer.
- **Transitions** (`Abort` overrides all rows):
  - IDLE: `Start` → ARM.
  - ARM, one cycle:
    - `Count==0 && !Done_Flag` → RUN.
    - otherwise → ERR with code 10.
  - RUN:
    - transfer with `Count==8` → WAIT_DONE. This is the 9th beat.
    - stall timeout → ERR with code 01.
    - otherwise stay in RUN.
  - WAIT_DONE:
    - `Done_Flag` → DONE.
    - `Done_Flag` low for 2 consecutive WAIT_DONE cycles → ERR with code 11.
  - DONE → IDLE, always one cycle.
  - ERR:
    - `Start` → ARM, and `Err_Code` clears.
    - otherwise hold.
  - `Abort` in any state → IDLE next edge. No `Burst_Done` is issued and `Err_Code` clears.
- **Stall counter:** 8-bit.
  - Cleared on RUN entry and on every transfer.
  - Incremented on each RUN cycle without a transfer.
  - If a RUN cycle has no transfer and stall == `TIMEOUT_CYCLES-1`, the next state is ERR. This means exactly `TIMEOUT_CYCLES` consecutive stall cycles cause a timeout.
- **Priority:** `Abort` > transfer > timeout. A transfer in the same cycle as the timeout threshold resets the counter and causes no fault.
- `Start` in ARM, RUN, WAIT_DONE or DONE is ignored.
- `Start` and `Abort` in the same cycle → IDLE.
- No beat can be transferred in WAIT_DONE, DONE or ERR, so the counter never sees a 10th qualified event.

## Timing
- **Reset values:** state IDLE, stall counter 0, `Err_Code` 00. All outputs are 0.
- **Start-to-first-beat:** `Start` sampled at edge 0 → ARM in cycle 1 → RUN in cycle 2. The first transfer is possible in cycle 2.
- **Zero-stall burst:** transfers occur in cycles 2..10.
  - `Done_Flag` is high from cycle 11.
  - WAIT_DONE in cycle 11, DONE in cycle 12 (`Burst_Done` high), IDLE in cycle 13.
  - `Busy` is high in cycles 1..11.
- **Handshake:** `Out_Valid` may drop without a transfer; the consumer must sample only on `Out_Valid & Out_Ready`. Backpressure (`Out_Ready`=0) holds `Show_DATA` low, so `Count` does not advance.
- **DONE → IDLE:** `En_Count` falls, and the counter is cleared on the next edge, before any subsequent ARM check.
- **Reset mid-burst:** immediate IDLE with all outputs 0. No pulse is generated.

## Test plan
- **Nominal burst:** `Start` pulse, with `Dp_Valid`=`Out_Ready`=1 and a `Count_Data` model → exactly 9 `Dp_Advance` pulses in cycles 2..10, `Burst_Done` only in cycle 12, `Count` back to 0 in cycle 13.
- **Backpressure:** toggle `Out_Ready` 1/0 each cycle → still 9 transfers, `Show_DATA` never high while `Out_Ready` is low, `Burst_Done` after the 9th beat, no error.
- **Timeout:** `TIMEOUT_CYCLES`=4, 3 beats, then `Dp_Valid`=0 → ERR entered after 4 stall cycles with `Err_Code`=01 and `En_Count`=0. A subsequent `Start` clears the fault and leads to ARM.
- **Timeout boundary:** 3 stall cycles, then a transfer on the 4th → no error, and the burst completes.
- **Counter faults:**
  - `Count` forced to 5 at ARM → `Err_Code`=10.
  - `Done_Flag` stuck low → `Err_Code`=11 two cycles after WAIT_DONE entry.
- **Abort and reset:** `Abort` at beat 5 → IDLE next cycle, no `Burst_Done`, no `Err_Flag`. `Start`+`Abort` together → stays IDLE. `RST` low mid-RUN → all outputs 0 asynchronously.
